// File: rtl/sweeper_pkg.sv
// rtl/sweeper_pkg.sv - shared types and sizes for the truth-table sweeper
package sweeper_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int NUM_PATTERNS = 8;
  localparam int IDX_W        = 3;
  localparam int CNT_W        = 4;
  localparam int HOLD_W       = 8;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PATTERNS - 1);

endpackage

// File: rtl/truth_table_sweeper_hold_timer.sv
// rtl/truth_table_sweeper_hold_timer.sv - per-pattern settle counter for the sweeper
module hold_timer
  import sweeper_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam logic [HOLD_W-1:0] LAST_COUNT = HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] count_q;

  // load wins over en so the closing cycle of a pattern restarts from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expire = (count_q == LAST_COUNT);

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - walks {a,b,c} through all patterns and captures q into a truth table
module truth_table_sweeper
  import sweeper_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    q,
  output logic                    a,
  output logic                    b,
  output logic                    c,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_PATTERNS-1:0] table_out,
  output logic [CNT_W-1:0]        ones_count
);

  state_e                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic [IDX_W-1:0]        idx_d;
  logic [IDX_W-1:0]        abc_q;
  logic                    busy_q;
  logic                    done_q;
  logic [NUM_PATTERNS-1:0] table_q;
  logic [NUM_PATTERNS-1:0] table_d;
  logic [CNT_W-1:0]        ones_q;
  logic [CNT_W-1:0]        ones_d;
  logic                    expire;
  logic                    timer_load;
  logic                    timer_en;

  always_comb begin
    timer_load     = ((state_q == IDLE) && start) || ((state_q == DRIVE) && expire);
    timer_en       = (state_q == DRIVE);
    idx_d          = idx_q + 1'b1;
    ones_d         = ones_q + CNT_W'(q);
    table_d        = table_q;
    table_d[idx_q] = q;
  end

  hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (timer_load),
    .en     (timer_en),
    .expire (expire)
  );

  // q is sampled on the closing edge of each pattern, while {a,b,c} still equals idx
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      abc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      table_q <= '0;
      ones_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= DRIVE;
            idx_q   <= '0;
            abc_q   <= '0;
            busy_q  <= 1'b1;
            table_q <= '0;
            ones_q  <= '0;
          end
        end
        DRIVE: begin
          if (expire) begin
            table_q <= table_d;
            ones_q  <= ones_d;
            if (idx_q == LAST_IDX) begin
              state_q <= DONE;
              abc_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_d;
              abc_q <= idx_d;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          abc_q   <= '0;
        end
      endcase
    end
  end

  assign {a, b, c}  = abc_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign table_out  = table_q;
  assign ones_count = ones_q;

endmodule
